// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: memory aluop codes, FSM encodings and
// helpers that classify ops and build the store byte lanes.
package mem_stage_pkg;

  localparam int DW  = 32;
  localparam int OPW = 8;
  localparam int RAW = 5;

  localparam logic [DW-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [OPW-1:0] OP_NOP = 8'b0000_0000;
  localparam logic [OPW-1:0] OP_ADD = 8'b0010_0000;
  localparam logic [OPW-1:0] OP_LB  = 8'b1110_0000;
  localparam logic [OPW-1:0] OP_LH  = 8'b1110_0001;
  localparam logic [OPW-1:0] OP_LW  = 8'b1110_0011;
  localparam logic [OPW-1:0] OP_LBU = 8'b1110_0100;
  localparam logic [OPW-1:0] OP_LHU = 8'b1110_0101;
  localparam logic [OPW-1:0] OP_SB  = 8'b1110_1000;
  localparam logic [OPW-1:0] OP_SH  = 8'b1110_1001;
  localparam logic [OPW-1:0] OP_SW  = 8'b1110_1011;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  typedef struct packed {
    logic [3:0]    be;
    logic [DW-1:0] wdata;
  } bus_lanes_t;

  function automatic logic is_load(input logic [OPW-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [OPW-1:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [OPW-1:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      OP_LW, OP_SW:         misaligned = (a != 2'b00);
      default:              misaligned = 1'b0;
    endcase
  endfunction

  // Loads read the whole word; stores replicate the datum across every lane
  function automatic bus_lanes_t store_lanes(input logic [OPW-1:0] op, input logic [1:0] a,
                                             input logic [DW-1:0] data);
    bus_lanes_t l;
    l.be    = 4'b1111;
    l.wdata = ZERO_WORD;
    case (op)
      OP_SB: begin
        l.be    = 4'b0001 << a;
        l.wdata = {4{data[7:0]}};
      end
      OP_SH: begin
        l.be    = a[1] ? 4'b1100 : 4'b0011;
        l.wdata = {2{data[15:0]}};
      end
      OP_SW: l.wdata = data;
      default: l.be = 4'b1111;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus req/ack interface between the MEM stage (master) and memory (slave).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic          bus_req;
  logic          bus_we;
  logic [DW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;

  modport master (output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                  input  bus_rdata, bus_ack);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                  output bus_rdata, bus_ack);
endinterface

// File: rtl/mem_load_align.sv
// Load formatter: picks the addressed byte/half lane of a little-endian word
// and sign- or zero-extends it according to the load op.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [OPW-1:0] i_op,
  input  logic [1:0]     i_a,
  input  logic [DW-1:0]  i_rdata,
  output logic [DW-1:0]  o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane extraction and extension
  always_comb begin
    w_byte = i_rdata[{i_a, 3'b000} +: 8];
    w_half = i_a[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_op)
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'h00_0000, w_byte};
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through and runs one req/ack bus
// transaction per aligned load/store while holding the pipeline.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [RAW-1:0] i_wd,
  input  logic           i_wreg,
  input  logic [DW-1:0]  i_wdata,
  input  logic [OPW-1:0] i_aluop,
  input  logic [DW-1:0]  i_mem_addr,
  input  logic [DW-1:0]  i_reg2,
  output logic [RAW-1:0] o_wd,
  output logic           o_wreg,
  output logic [DW-1:0]  o_wdata,
  output logic           stall_req,
  output logic           exc_adel,
  output logic           exc_ades,
  mem_stage_if.master    bus
);

  logic [1:0]     r_state;
  logic [OPW-1:0] r_op;
  logic [1:0]     r_a;
  logic [DW-1:0]  r_rdata;
  logic           r_bus_req;
  logic           r_bus_we;
  logic [DW-1:0]  r_bus_addr;
  logic [3:0]     r_bus_be;
  logic [DW-1:0]  r_bus_wdata;

  logic           w_mem;
  logic           w_misal;
  logic           w_start;
  bus_lanes_t     w_lanes;
  logic [DW-1:0]  w_load_word;

  mem_load_align u_load_align (
    .i_op    (r_op),
    .i_a     (r_a),
    .i_rdata (r_rdata),
    .o_data  (w_load_word)
  );

  // Classify the incoming op
  always_comb begin
    w_mem   = is_load(i_aluop) || is_store(i_aluop);
    w_misal = w_mem && misaligned(i_aluop, i_mem_addr[1:0]);
    w_start = (r_state == S_IDLE) && w_mem && !w_misal;
    w_lanes = store_lanes(i_aluop, i_mem_addr[1:0], i_reg2);
  end

  // Pipeline outputs, stall and exceptions; all quiet while in reset
  always_comb begin
    o_wd      = i_wd;
    o_wreg    = 1'b0;
    o_wdata   = i_wdata;
    stall_req = 1'b0;
    exc_adel  = 1'b0;
    exc_ades  = 1'b0;
    if (rst) begin
      stall_req = 1'b0;
    end else begin
      o_wreg   = i_wreg && !w_misal;
      exc_adel = w_misal && is_load(i_aluop);
      exc_ades = w_misal && is_store(i_aluop);
      case (r_state)
        S_IDLE:  stall_req = w_start;
        S_BUSY:  stall_req = 1'b1;
        S_DONE:  o_wdata = is_load(r_op) ? w_load_word : i_wdata;
        default: stall_req = 1'b0;
      endcase
    end
  end

  // Transaction FSM; bus signals are launched in IDLE and frozen until the ack
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NOP;
      r_a         <= 2'b00;
      r_rdata     <= ZERO_WORD;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= ZERO_WORD;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= ZERO_WORD;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= is_store(i_aluop);
            r_bus_addr  <= {i_mem_addr[DW-1:2], 2'b00};
            r_bus_be    <= w_lanes.be;
            r_bus_wdata <= w_lanes.wdata;
            r_op        <= i_aluop;
            r_a         <= i_mem_addr[1:0];
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.bus_ack) begin
            r_rdata   <= bus.bus_rdata;
            r_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset corner sequences and
// randomized ops checked against a lane-arithmetic reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  i_wd;
  logic        i_wreg;
  logic [31:0] i_wdata, i_mem_addr, i_reg2;
  logic [7:0]  i_aluop;
  logic [4:0]  o_wd;
  logic        o_wreg, stall_req, exc_adel, exc_ades;
  logic [31:0] o_wdata;

  always #5 clk = ~clk;

  mem_stage_if bif();

  mem_stage dut (
    .clk(clk), .rst(rst), .i_wd(i_wd), .i_wreg(i_wreg), .i_wdata(i_wdata),
    .i_aluop(i_aluop), .i_mem_addr(i_mem_addr), .i_reg2(i_reg2),
    .o_wd(o_wd), .o_wreg(o_wreg), .o_wdata(o_wdata), .stall_req(stall_req),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus(bif)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr, reg2, wdata, rdata;
    logic        wreg;
    logic [4:0]  wd;
    int          dly;
    logic [31:0] e_wdata;
    logic        e_wreg;
    int          e_stall;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_bwdata;
    logic        e_adel, e_ades;
  } vec_t;

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    int          stall;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, bwdata;
    logic        adel, ades, unstable, req_after, done;
  } obs_t;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[13];
  logic [7:0] op_pool[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, reg2, wdata, rdata,
                              input int dly, input logic [31:0] e_wdata, input logic e_wreg,
                              input int e_stall, input logic e_req, e_we, input logic [3:0] e_be,
                              input logic [31:0] e_addr, e_bwdata, input logic e_adel, e_ades);
    vec_t v;
    v.op = op; v.addr = addr; v.reg2 = reg2; v.wdata = wdata; v.rdata = rdata;
    v.wreg = 1'b1; v.wd = 5'(addr[4:0] ^ 5'd9); v.dly = dly;
    v.e_wdata = e_wdata; v.e_wreg = e_wreg; v.e_stall = e_stall; v.e_req = e_req;
    v.e_we = e_we; v.e_be = e_be; v.e_addr = e_addr; v.e_bwdata = e_bwdata;
    v.e_adel = e_adel; v.e_ades = e_ades;
    return v;
  endfunction

  // Reference: access size, alignment and lane position computed arithmetically
  function automatic vec_t model(input vec_t v);
    vec_t e = v;
    int a, sz;
    bit ld, st, sgn, mis;
    logic [31:0] lane;
    a = int'(v.addr & 32'd3);
    ld = 1'b0; st = 1'b0; sgn = 1'b0; sz = 4;
    case (v.op)
      OP_LB:  begin ld = 1'b1; sz = 1; sgn = 1'b1; end
      OP_LBU: begin ld = 1'b1; sz = 1; end
      OP_LH:  begin ld = 1'b1; sz = 2; sgn = 1'b1; end
      OP_LHU: begin ld = 1'b1; sz = 2; end
      OP_LW:  ld = 1'b1;
      OP_SB:  begin st = 1'b1; sz = 1; end
      OP_SH:  begin st = 1'b1; sz = 2; end
      OP_SW:  st = 1'b1;
      default: ;
    endcase
    mis = (ld || st) && ((a % sz) != 0);
    e.e_adel = ld && mis;
    e.e_ades = st && mis;
    e.e_wreg = mis ? 1'b0 : v.wreg;
    e.e_req = (ld || st) && !mis;
    e.e_stall = e.e_req ? v.dly + 2 : 0;
    e.e_we = st;
    e.e_addr = v.addr & 32'hFFFF_FFFC;
    e.e_be = ld ? 4'hF : 4'(((1 << sz) - 1) << a);
    if (sz == 1)      e.e_bwdata = (v.reg2 & 32'hFF) * 32'h0101_0101;
    else if (sz == 2) e.e_bwdata = (v.reg2 & 32'hFFFF) * 32'h0001_0001;
    else              e.e_bwdata = v.reg2;
    lane = v.rdata >> (8 * a);
    if (e.e_req && ld) begin
      if (sz == 1)      e.e_wdata = (sgn && lane[7])  ? ((lane & 32'hFF) | 32'hFFFF_FF00) : (lane & 32'hFF);
      else if (sz == 2) e.e_wdata = (sgn && lane[15]) ? ((lane & 32'hFFFF) | 32'hFFFF_0000) : (lane & 32'hFFFF);
      else              e.e_wdata = v.rdata;
    end else begin
      e.e_wdata = v.wdata;
    end
    return e;
  endfunction

  // Drive one op from just after a rising edge; act as the memory and observe
  task automatic run_op(input vec_t v, output obs_t o);
    int since_req;
    o = '{default: 0};
    since_req = 0;
    i_aluop = v.op; i_mem_addr = v.addr; i_reg2 = v.reg2; i_wdata = v.wdata;
    i_wreg = v.wreg; i_wd = v.wd;
    for (int cyc = 0; cyc < 20 && !o.done; cyc++) begin
      @(negedge clk);
      bif.bus_ack = 1'b0;
      if (stall_req) o.stall++;
      if (bif.bus_req) begin
        if (!o.req) begin
          o.req = 1'b1; o.we = bif.bus_we; o.be = bif.bus_be;
          o.addr = bif.bus_addr; o.bwdata = bif.bus_wdata;
        end else if (o.we !== bif.bus_we || o.be !== bif.bus_be ||
                     o.addr !== bif.bus_addr || o.bwdata !== bif.bus_wdata) begin
          o.unstable = 1'b1;
        end
        if (since_req == v.dly) begin
          bif.bus_ack = 1'b1;
          bif.bus_rdata = v.rdata;
        end else begin
          bif.bus_rdata = $urandom();
        end
        since_req++;
      end
      if (!stall_req) begin
        o.done = 1'b1; o.wdata = o_wdata; o.wreg = o_wreg; o.wd = o_wd;
        o.adel = exc_adel; o.ades = exc_ades;
      end
    end
    @(posedge clk);
    #1;
    o.req_after = bif.bus_req;
  endtask

  task automatic compare(input string tag, input vec_t v, input obs_t o);
    chk({tag, ".done"}, 32'(o.done), 32'd1);
    chk({tag, ".wdata"}, o.wdata, v.e_wdata);
    chk({tag, ".wd"}, 32'(o.wd), 32'(v.wd));
    chk({tag, ".wreg"}, 32'(o.wreg), 32'(v.e_wreg));
    chk({tag, ".stall_cycles"}, 32'(o.stall), 32'(v.e_stall));
    chk({tag, ".bus_req_seen"}, 32'(o.req), 32'(v.e_req));
    chk({tag, ".bus_req_after"}, 32'(o.req_after), 32'd0);
    chk({tag, ".exc_adel"}, 32'(o.adel), 32'(v.e_adel));
    chk({tag, ".exc_ades"}, 32'(o.ades), 32'(v.e_ades));
    if (v.e_req) begin
      chk({tag, ".bus_we"}, 32'(o.we), 32'(v.e_we));
      chk({tag, ".bus_be"}, 32'(o.be), 32'(v.e_be));
      chk({tag, ".bus_addr"}, o.addr, v.e_addr);
      chk({tag, ".bus_stable"}, 32'(o.unstable), 32'd0);
      if (v.e_we) chk({tag, ".bus_wdata"}, o.bwdata, v.e_bwdata);
    end
  endtask

  initial begin
    obs_t o;
    vec_t v;
    op_pool = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ADD, 8'h25};
    //            op      addr          reg2          wdata         rdata         dly e_wdata       wr st rq we be     e_addr        e_bwdata      adel ades
    tbl[0]  = mk(OP_ADD, 32'h0000_0000, 32'h0,        32'h0000_0005, 32'h0,        0, 32'h0000_0005, 1, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 0);
    tbl[1]  = mk(OP_LW,  32'h0000_1000, 32'h0,        32'h0000_1000, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 3, 1, 0, 4'hF, 32'h0000_1000, 32'h0,        0, 0);
    tbl[2]  = mk(OP_LB,  32'h0000_1003, 32'h0,        32'h0000_1003, 32'h80FFFFFF, 0, 32'hFFFFFF80, 1, 2, 1, 0, 4'hF, 32'h0000_1000, 32'h0,        0, 0);
    tbl[3]  = mk(OP_LBU, 32'h0000_1003, 32'h0,        32'h0000_1003, 32'h80FFFFFF, 0, 32'h00000080, 1, 2, 1, 0, 4'hF, 32'h0000_1000, 32'h0,        0, 0);
    tbl[4]  = mk(OP_SH,  32'h0000_2002, 32'h1234ABCD, 32'h0000_2002, 32'h0,        0, 32'h0000_2002, 1, 2, 1, 1, 4'hC, 32'h0000_2000, 32'hABCDABCD, 0, 0);
    tbl[5]  = mk(OP_LW,  32'h0000_1001, 32'h0,        32'h0000_1001, 32'h0,        0, 32'h0000_1001, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        1, 0);
    tbl[6]  = mk(OP_SW,  32'h0000_1002, 32'h0,        32'h0000_1002, 32'h0,        0, 32'h0000_1002, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 1);
    tbl[7]  = mk(OP_LH,  32'h0000_0002, 32'h0,        32'h0000_0002, 32'h80017FFF, 2, 32'hFFFF8001, 1, 4, 1, 0, 4'hF, 32'h0,        32'h0,        0, 0);
    tbl[8]  = mk(OP_LHU, 32'h0000_0002, 32'h0,        32'h0000_0002, 32'h80017FFF, 0, 32'h00008001, 1, 2, 1, 0, 4'hF, 32'h0,        32'h0,        0, 0);
    tbl[9]  = mk(OP_SB,  32'h0000_3001, 32'h1122335A, 32'h0000_3001, 32'h0,        1, 32'h0000_3001, 1, 3, 1, 1, 4'h2, 32'h0000_3000, 32'h5A5A5A5A, 0, 0);
    tbl[10] = mk(OP_SW,  32'h0000_4000, 32'hCAFEF00D, 32'h0000_4000, 32'h0,        3, 32'h0000_4000, 1, 5, 1, 1, 4'hF, 32'h0000_4000, 32'hCAFEF00D, 0, 0);
    tbl[11] = mk(OP_LH,  32'h0000_0005, 32'h0,        32'h0000_5555, 32'h0,        0, 32'h0000_5555, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        1, 0);
    tbl[12] = mk(OP_SB,  32'h0000_0003, 32'h000000A7, 32'h0000_0003, 32'h0,        0, 32'h0000_0003, 1, 2, 1, 1, 4'h8, 32'h0,        32'hA7A7A7A7, 0, 0);

    // Reset with a misaligned load presented: everything must stay quiet
    rst = 1'b1; i_aluop = OP_LW; i_mem_addr = 32'h0000_1001; i_reg2 = 32'h0;
    i_wdata = 32'h0; i_wreg = 1'b1; i_wd = 5'd7;
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.o_wreg", 32'(o_wreg), 32'd0);
    chk("rst.stall_req", 32'(stall_req), 32'd0);
    chk("rst.exc_adel", 32'(exc_adel), 32'd0);
    chk("rst.o_wd", 32'(o_wd), 32'd7);
    chk("rst.bus_req", 32'(bif.bus_req), 32'd0);
    chk("rst.bus_we", 32'(bif.bus_we), 32'd0);
    chk("rst.bus_be", 32'(bif.bus_be), 32'd0);
    chk("rst.bus_addr", bif.bus_addr, 32'd0);
    chk("rst.bus_wdata", bif.bus_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_aluop = OP_ADD;

    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i], o);
      compare($sformatf("vec%0d", i), tbl[i], o);
    end

    // Reset while BUSY, then a late ack that must be ignored
    i_aluop = OP_LW; i_mem_addr = 32'h0000_1000; i_wdata = 32'h0;
    @(negedge clk);
    chk("rbusy.idle_stall", 32'(stall_req), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rbusy.bus_req", 32'(bif.bus_req), 32'd1);
    chk("rbusy.busy_stall", 32'(stall_req), 32'd1);
    rst = 1'b1; i_aluop = OP_ADD; i_wdata = 32'h0000_0077;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rbusy.req_dropped", 32'(bif.bus_req), 32'd0);
    chk("rbusy.stall_after", 32'(stall_req), 32'd0);
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    chk("rbusy.late_ack_req", 32'(bif.bus_req), 32'd0);
    chk("rbusy.late_ack_stall", 32'(stall_req), 32'd0);
    chk("rbusy.late_ack_wdata", o_wdata, 32'h0000_0077);
    @(posedge clk);
    #1;

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      v.op = op_pool[$urandom_range(0, 9)];
      v.addr = $urandom();
      v.reg2 = $urandom();
      v.wdata = $urandom();
      v.rdata = $urandom();
      v.wreg = 1'($urandom_range(0, 1));
      v.wd = 5'($urandom_range(0, 31));
      v.dly = $urandom_range(0, 3);
      v = model(v);
      run_op(v, o);
      compare($sformatf("rnd%0d", i), v, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
